// File: rtl/pipe_stage_buf.sv
// Pipeline-stage buffer for the valid/allow_in handshake: DEPTH-entry circular FIFO with ready_go gating,
// synchronous flush and occupancy count. Define PIPE_BUF_BYPASS_EN for zero-latency pass-through when empty.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              allow_in,
  input  logic              ready_go,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_allow_in,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic empty;
  logic bypass;
  logic push;
  logic pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    empty     = (count_q == '0);
`ifdef PIPE_BUF_BYPASS_EN
    bypass    = empty & in_valid & ready_go & out_allow_in & ~flush;
`else
    bypass    = 1'b0;
`endif
    out_valid = (~empty & ready_go & ~flush) | bypass;
    out_data  = bypass ? in_data : mem_q[rd_ptr_q];

    // A bypassed entry never touches storage, so only stored entries pop.
    pop       = ~empty & ready_go & ~flush & out_allow_in;
    allow_in  = (count_q < CNT_W'(DEPTH)) | pop | flush;
    push      = in_valid & allow_in & ~flush & ~bypass;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    count = count_q;
    full  = (count_q == CNT_W'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates out_valid, so stale payloads are never offered.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer implementing the core's `valid` / `allow_in` handshake between two adjacent stages (IF→ID, ID→EX, EX→MEM, MEM→WB). It generalises the single-entry stage latch to DATA_W-wide payloads and DEPTH entries of circular buffering. It adds a stage-local `ready_go` gate, a synchronous flush, and an occupancy count. One instance replaces each hand-written inter-stage valid/data register pair in `mycpu_top`.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- DEPTH, 1, buffer entries (≥1, need not be a power of two); DEPTH=1 is the classic stage latch
- CNT_W, $clog2(DEPTH+1), width of `count`
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- flush  in  1  discard all entries and any push this cycle
- in_valid  in  1  upstream offers an entry (e.g. IF_to_ID_valid)
- in_data  in  DATA_W  upstream payload
- allow_in  out  1  this buffer accepts `in_data` this cycle
- ready_go  in  1  head entry has finished this stage's work and may leave
- out_valid  out  1  head entry offered downstream (e.g. ID_to_EX_valid)
- out_data  out  DATA_W  head payload; defined only while `out_valid`=1
- out_allow_in  in  1  downstream accepts (e.g. EX_allow_in)
- count  out  CNT_W  entries currently held
- full  out  1  `count`==DEPTH

## Operation
- Storage: DEPTH×DATA_W array, `wr_ptr`, `rd_ptr` (0..DEPTH-1), `count` (0..DEPTH).
- pop = out_valid & out_allow_in; push = in_valid & allow_in & ~flush (& ~bypass when bypass is compiled in).
- out_valid = (count≠0) & ready_go & ~flush.
- allow_in = (count<DEPTH) | pop | flush. Combinational path from `out_allow_in` to `allow_in` is intended (full buffer frees a slot in the same cycle it drains).
- push: write `in_data` at `wr_ptr`; `wr_ptr` ← wr_ptr+1, wrapping from DEPTH-1 to 0.
- pop: `rd_ptr` ← rd_ptr+1 with the same wrap.
- count ← count + push − pop; simultaneous push and pop keeps `count` unchanged, including when full.
- push and pop with count==0 (bypass off): push only; the entry becomes visible next cycle.
- flush: next cycle count=0, wr_ptr=rd_ptr=0. `out_valid`=0 in the flush cycle. Pushes in that cycle are dropped. Storage contents are not cleared.
- reset has priority over flush. Reset mid-transfer drops all entries.
- ready_go=0 holds the head entry. Pushes continue until full.
- Entries leave strictly in arrival order; no entry is duplicated or lost except by flush/reset.

## Timing
- Reset values: count=0, full=0, out_valid=0, allow_in=1; out_data don't-care.
- Latency without bypass: an entry pushed at edge N is offered at `out_valid` in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained at any DEPTH, provided ready_go=1 and out_allow_in=1.
- `out_valid`/`out_data` are registered-state functions gated only by `ready_go` and `flush`. `allow_in` additionally depends on `out_allow_in`.
- Full with no pop: allow_in=0; upstream must hold `in_valid`/`in_data`.

## Configuration
- `PIPE_BUF_BYPASS_EN` defined: when count==0, in_valid=1, ready_go=1, out_allow_in=1, flush=0, the input passes through combinationally. In that case out_valid=1 and out_data=in_data, nothing is written, and pointers/count are unchanged. Zero-cycle latency when empty.
- `PIPE_BUF_BYPASS_EN` undefined: no combinational in→out path; minimum latency is one cycle. This is the default for timing closure.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 → count=0, out_valid=0, allow_in=1 on the cycle after release.
- DEPTH=1 stream, in_data=0x1..0x10, ready_go=out_allow_in=1 → out_data 0x1..0x10 in order, one per cycle after 1-cycle latency; count never exceeds 1.
- DEPTH=3, out_allow_in=0, push 0xA,0xB,0xC,0xD → full=1 after 3 pushes; allow_in=0 and 0xD held. Then out_allow_in=1 for 4 cycles → pops A,B,C,D. Same-cycle push/pop at full keeps count=3; pointers wrap past 2.
- ready_go=0 with 2 entries, out_allow_in=1 → out_valid=0, count stays 2. ready_go=1 → pops resume in order.
- flush with count=2 and in_valid=1 (0x55) → out_valid=0 that cycle; next cycle count=0 and 0x55 never appears at the output.
- Bypass build, empty buffer, in_data=0x77, all ready → out_valid=1, out_data=0x77 in the same cycle, count stays 0. Non-bypass build with the same stimulus → 0x77 appears one cycle later.
